// File: rtl/seq_detector.sv
// Serial pattern detector fed by the registered bit stream of an upstream DFF stage.
// Shifts accepted bits into a PAT_W-wide window and pulses match for one cycle whenever
// the window equals PATTERN. Overlapping matches are allowed or suppressed according to
// OVERLAP. A saturating match counter and a sticky overflow flag are also kept.
//
// Optional build macro SEQ_DET_SYNC_EN: when defined, din passes through two free-running
// flops before the shift register, which adds two cycles of latency.
module seq_detector #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 8,
  parameter bit                   OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf,
  output logic [PAT_W-1:0] window,
  output logic             armed
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  typedef enum logic [0:0] {StFill, StDetect} state_e;

  state_e           state_q;
  logic [FillW-1:0] fill_q;
  logic [PAT_W-1:0] window_q;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             bit_in;
  logic [PAT_W-1:0] win_shift;
  logic [FillW-1:0] fill_inc;
  logic             hit;

`ifdef SEQ_DET_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop retiming of din; runs every edge regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign bit_in = sync_q[1];
`else
  assign bit_in = din;
`endif

  // Candidate next window/fill for an accepted bit and the resulting match decision.
  always_comb begin
    win_shift = {window_q[PAT_W-2:0], bit_in};
    fill_inc  = fill_q;
    unique case (state_q)
      StFill:   fill_inc = fill_q + FillW'(1);
      StDetect: fill_inc = fill_q;
      default:  fill_inc = fill_q;
    endcase
    // fill gating keeps X in a partially filled window out of the match path.
    hit = (fill_inc == FillFull) && (win_shift == PATTERN);
  end

  // FSM, window, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      fill_q   <= '0;
      window_q <= '0;
      match_q  <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (en) begin
        window_q <= win_shift;
        if (hit) begin
          match_q <= 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) begin
            ovf_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (OVERLAP) begin
            fill_q  <= FillFull;
            state_q <= StDetect;
          end else begin
            // Restart: the matched bits stay visible but cannot seed the next match.
            fill_q  <= '0;
            state_q <= StFill;
          end
        end else begin
          fill_q  <= fill_inc;
          state_q <= (fill_inc == FillFull) ? StDetect : StFill;
        end
      end
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cnt_ovf   = ovf_q;
  assign window    = window_q;
  assign armed     = (state_q == StDetect);

endmodule

// File: tb/tb_seq_detector.sv
// Randomized self-checking bench for seq_detector. Three instances share one stimulus
// stream: defaults, OVERLAP=0, and a saturating CNT_W=2 / PATTERN=1111 variant.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din = 1'b0;

  logic       d_match, d_ovf, d_armed;
  logic [7:0] d_cnt;
  logic [3:0] d_win;
  logic       n_match, n_ovf, n_armed;
  logic [7:0] n_cnt;
  logic [3:0] n_win;
  logic       s_match, s_ovf, s_armed;
  logic [1:0] s_cnt;
  logic [3:0] s_win;

  seq_detector u_dflt (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .match(d_match), .match_cnt(d_cnt), .cnt_ovf(d_ovf), .window(d_win), .armed(d_armed)
  );

  seq_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .match(n_match), .match_cnt(n_cnt), .cnt_ovf(n_ovf), .window(n_win), .armed(n_armed)
  );

  seq_detector #(.CNT_W(2), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .match(s_match), .match_cnt(s_cnt), .cnt_ovf(s_ovf), .window(s_win), .armed(s_armed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per instance, the accepted-bit window, bits accepted since the last
  // restart, match count (clamped), sticky overflow and the last-edge match pulse.
  int unsigned pat  [3] = '{4'b1011, 4'b1011, 4'b1111};
  int unsigned cmax [3] = '{255, 255, 3};
  bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned m_win   [3];
  int unsigned m_fresh [3];
  int unsigned m_cnt   [3];
  bit          m_ovf   [3];
  bit          m_match [3];
`ifdef SEQ_DET_SYNC_EN
  bit dly [$] = '{1'b0, 1'b0};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit d);
    bit s;
`ifdef SEQ_DET_SYNC_EN
    s = dly.pop_front();
    dly.push_back(d);
    if (r) dly = '{1'b0, 1'b0};
`else
    s = d;
`endif
    for (int i = 0; i < 3; i++) begin
      m_match[i] = 1'b0;
      if (r) begin
        m_win[i] = 0; m_fresh[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end else if (e) begin
        m_win[i] = ((m_win[i] << 1) | s) % 16;
        m_fresh[i]++;
        if (m_fresh[i] >= 4 && m_win[i] == pat[i]) begin
          m_match[i] = 1'b1;
          if (m_cnt[i] == cmax[i]) m_ovf[i] = 1'b1;
          else m_cnt[i]++;
          if (!ovl[i]) m_fresh[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("dflt_match", 32'(d_match), 32'(m_match[0]));
    check("dflt_cnt",   32'(d_cnt),   m_cnt[0]);
    check("dflt_ovf",   32'(d_ovf),   32'(m_ovf[0]));
    check("dflt_win",   32'(d_win),   m_win[0]);
    check("dflt_armed", 32'(d_armed), 32'(m_fresh[0] >= 4));
    check("novl_match", 32'(n_match), 32'(m_match[1]));
    check("novl_cnt",   32'(n_cnt),   m_cnt[1]);
    check("novl_ovf",   32'(n_ovf),   32'(m_ovf[1]));
    check("novl_win",   32'(n_win),   m_win[1]);
    check("novl_armed", 32'(n_armed), 32'(m_fresh[1] >= 4));
    check("sat_match",  32'(s_match), 32'(m_match[2]));
    check("sat_cnt",    32'(s_cnt),   m_cnt[2]);
    check("sat_ovf",    32'(s_ovf),   32'(m_ovf[2]));
    check("sat_win",    32'(s_win),   m_win[2]);
    check("sat_armed",  32'(s_armed), 32'(m_fresh[2] >= 4));
  endtask

  // Apply inputs, take one rising edge, advance the model, then compare on the falling edge.
  task automatic step(input bit r, input bit e, input bit d);
    rst = r; en = e; din = d;
    @(posedge clk);
    model_step(r, e, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic feed(input int unsigned bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k]);
  endtask

  initial begin
    @(negedge clk);
    // Reset with din=1, en=1 held high.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_win",   32'(d_win), 32'h0);
    check("rst_match", 32'(d_match), 32'h0);
    check("rst_cnt",   32'(d_cnt), 32'h0);
    check("rst_armed", 32'(d_armed), 32'h0);
    check("rst_ovf",   32'(d_ovf), 32'h0);

    // Basic detect 1011.
    feed(4'b1011, 4);
`ifndef SEQ_DET_SYNC_EN
    check("basic_match", 32'(d_match), 32'h1);
    check("basic_cnt",   32'(d_cnt), 32'h1);
    check("basic_win",   32'(d_win), 32'hb);
    check("basic_armed", 32'(d_armed), 32'h1);
`endif
    step(1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", 32'(d_match), 32'h0);

    // Overlap stream 1011011.
    step(1'b1, 1'b0, 1'b0);
    feed(4'b1011, 4);
`ifndef SEQ_DET_SYNC_EN
    check("novl_disarm", 32'(n_armed), 32'h0);
`endif
    feed(3'b011, 3);
`ifndef SEQ_DET_SYNC_EN
    check("ovl_cnt",   32'(d_cnt), 32'h2);
    check("ovl_match", 32'(d_match), 32'h1);
`endif

    // Enable hold: 101, three idle edges with din=0, then 1.
    step(1'b1, 1'b0, 1'b0);
    feed(3'b101, 3);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("hold_match", 32'(d_match), 32'h0);
    end
    step(1'b0, 1'b1, 1'b1);
`ifndef SEQ_DET_SYNC_EN
    check("hold_match_final", 32'(d_match), 32'h1);
`endif

    // Mid-pattern reset.
    step(1'b1, 1'b0, 1'b0);
    feed(3'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
`ifndef SEQ_DET_SYNC_EN
    check("midrst_win",   32'(d_win), 32'h1);
    check("midrst_armed", 32'(d_armed), 32'h0);
    check("midrst_match", 32'(d_match), 32'h0);
`endif

    // Saturation: eight ones into the CNT_W=2 / 1111 instance.
    step(1'b1, 1'b0, 1'b0);
    feed(8'hff, 8);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("sat_cnt_final", 32'(s_cnt), 32'h3);
    check("sat_ovf_final", 32'(s_ovf), 32'h1);

    // Randomized traffic biased toward ones so both patterns occur often.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
